// File: rtl/mux8_pkg.sv
// Shared constants and FSM state type for the mux8 arbiter slice.
package mux8_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/mux8.sv
// Shared 8:1 single-bit mux used as the arbiter datapath.
module mux8
  import mux8_pkg::*;
(
  input  logic [NUM_REQ-1:0] a,
  input  logic [SEL_W-1:0]   select_line,
  output logic               y
);
  assign y = a[select_line];
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared mux8 with burst limit and valid/ready output.
// Optional MUX8_ARB_PRIO_EN: requester 0 wins every arbitration point (never preempts mid-burst).
module mux8_rr_arbiter
  import mux8_pkg::*;
#(
  parameter int MAX_BURST = 4
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] a,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   select_line,
  output logic               y,
  output logic               y_valid
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Returns {found, index}; scanning k from high to low leaves the nearest winner after last.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [SEL_W-1:0]   last);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   last_idx_q, last_idx_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               y_valid_q, y_valid_d;

  logic [SEL_W:0]     pick;
  logic               xfer;
  logic               others;
  logic               rearb;

  always_comb begin
    pick = rr_pick(req, last_idx_q);
`ifdef MUX8_ARB_PRIO_EN
    if (req[0]) pick = {1'b1, {SEL_W{1'b0}}};
`endif
    xfer        = y_valid_q && out_ready;
    others      = |(req & ~gnt_q);
    state_d     = state_q;
    last_idx_d  = last_idx_q;
    sel_d       = sel_q;
    burst_cnt_d = burst_cnt_q;
    gnt_d       = gnt_q;
    y_valid_d   = y_valid_q;
    rearb       = 1'b0;

    case (state_q)
      IDLE: rearb = |req;
      GRANT: begin
        if (!req[sel_q]) begin
          rearb = 1'b1;
        end else if (xfer) begin
          if (int'(burst_cnt_q) + 1 < MAX_BURST) burst_cnt_d = burst_cnt_q + 1'b1;
          else if (!others)                      burst_cnt_d = '0;
          else                                   rearb = 1'b1;
        end
      end
      default: rearb = 1'b0;
    endcase

    if (rearb) begin
      burst_cnt_d = '0;
      if (pick[SEL_W]) begin
        state_d    = GRANT;
        sel_d      = pick[SEL_W-1:0];
        last_idx_d = pick[SEL_W-1:0];
        gnt_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick[SEL_W-1:0];
        y_valid_d  = 1'b1;
      end else begin
        state_d   = IDLE;
        gnt_d     = '0;
        y_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_idx_q  <= 3'd7;
      sel_q       <= '0;
      burst_cnt_q <= '0;
      gnt_q       <= '0;
      y_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_idx_q  <= last_idx_d;
      sel_q       <= sel_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
      y_valid_q   <= y_valid_d;
    end
  end

  assign gnt         = gnt_q;
  assign select_line = sel_q;
  assign y_valid     = y_valid_q;

  mux8 u_mux (
    .a           (a),
    .select_line (sel_q),
    .y           (y)
  );
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: two instances (MAX_BURST 4 and 1) against an in-bench reference model.
module tb_mux8_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] a;
  logic       out_ready;
  logic [7:0] gnt_o [2];
  logic [2:0] sel_o [2];
  logic       y_o   [2];
  logic       yv_o  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .a(a), .out_ready(out_ready),
    .gnt(gnt_o[0]), .select_line(sel_o[0]), .y(y_o[0]), .y_valid(yv_o[0])
  );

  mux8_rr_arbiter #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .a(a), .out_ready(out_ready),
    .gnt(gnt_o[1]), .select_line(sel_o[1]), .y(y_o[1]), .y_valid(yv_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who holds the mux and how many transfers it has made in this grant.
  int mb_of    [2] = '{4, 1};
  bit m_busy   [2];
  int m_holder [2];
  int m_last   [2];
  int m_xfers  [2];
  int m_sel    [2];

  function automatic int pick(input logic [7:0] r, input int last);
`ifdef MUX8_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= 8; k++)
      if (r[(last + k) % 8]) return (last + k) % 8;
    return -1;
  endfunction

  task automatic model_rearb(input int i);
    int p;
    p = pick(req, m_last[i]);
    if (p < 0) begin
      m_busy[i] = 1'b0;
    end else begin
      m_busy[i]   = 1'b1;
      m_holder[i] = p;
      m_last[i]   = p;
      m_sel[i]    = p;
      m_xfers[i]  = 0;
    end
  endtask

  task automatic model_step(input int i);
    int  n;
    bit  others;
    if (!m_busy[i]) begin
      if (req != 8'h00) model_rearb(i);
    end else if (!req[m_holder[i]]) begin
      model_rearb(i);
    end else if (out_ready) begin
      n      = m_xfers[i] + 1;
      others = (req & ~(8'h01 << m_holder[i])) != 8'h00;
      if (n < mb_of[i])  m_xfers[i] = n;
      else if (!others)  m_xfers[i] = 0;
      else               model_rearb(i);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i]   = 1'b0;
        m_holder[i] = 0;
        m_last[i]   = 7;
        m_xfers[i]  = 0;
        m_sel[i]    = 0;
      end else begin
        model_step(i);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_gnt[%0d]", i), {24'h0, gnt_o[i]},
            m_busy[i] ? (32'h1 << m_holder[i]) : 32'h0);
        chk($sformatf("model_sel[%0d]", i), {29'h0, sel_o[i]}, m_sel[i]);
        chk($sformatf("model_yvalid[%0d]", i), {31'h0, yv_o[i]}, {31'h0, m_busy[i]});
        chk($sformatf("model_y[%0d]", i), {31'h0, y_o[i]}, {31'h0, a[m_sel[i]]});
      end
    end
  end

  logic [7:0] fair_seq [5] = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h02};

  initial begin
    int xf;
    int exp_sel;
    rst = 1'b1; req = 8'hFF; a = 8'h00; out_ready = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_gnt", {24'h0, gnt_o[i]}, 32'h0);
      chk("reset_sel", {29'h0, sel_o[i]}, 32'h0);
      chk("reset_yvalid", {31'h0, yv_o[i]}, 32'h0);
    end
    #1 rst = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("first_grant", {24'h0, gnt_o[i]}, 32'h01);
      chk("first_yvalid", {31'h0, yv_o[i]}, 32'h1);
    end
    #1 req = 8'h00;

    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("abort_to_idle", {24'h0, gnt_o[i]}, 32'h0);
    #1 req = 8'hAA; a = 8'hAA; out_ready = 1'b1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("fair_gnt%0d", k), {24'h0, gnt_o[1]}, {24'h0, fair_seq[k]});
      chk($sformatf("fair_y%0d", k), {31'h0, y_o[1]}, 32'h1);
    end

    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_rst_gnt", {24'h0, gnt_o[i]}, 32'h0);
      chk("async_rst_sel", {29'h0, sel_o[i]}, 32'h0);
      chk("async_rst_yvalid", {31'h0, yv_o[i]}, 32'h0);
    end

    @(negedge clk);
    #1 rst = 1'b0; req = 8'h03; a = 8'h01; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
`ifdef MUX8_ARB_PRIO_EN
      exp_sel = 0;
`else
      exp_sel = (k / 4) % 2;
`endif
      chk($sformatf("burst_sel%0d", k), {29'h0, sel_o[0]}, exp_sel);
      chk($sformatf("burst_gnt%0d", k), {24'h0, gnt_o[0]}, 32'h1 << exp_sel);
    end

    #1 req = 8'h04;
    xf = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk($sformatf("sole_gnt%0d", k), {24'h0, gnt_o[i]}, 32'h04);
      if (yv_o[0] && out_ready) xf++;
    end
    chk("sole_transfers", xf, 10);

    #1 out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_gnt", {24'h0, gnt_o[0]}, 32'h04);
      chk("bp_sel", {29'h0, sel_o[0]}, 32'h2);
      chk("bp_yvalid", {31'h0, yv_o[0]}, 32'h1);
    end
    #1 req = 8'h40;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("abort_handoff", {24'h0, gnt_o[i]}, 32'h40);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      a         = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the shared 8:1 single-bit mux (`mux8`). Eight requesters each present one data bit on `a[i]` and a request on `req[i]`; the block selects one requester, drives the mux `select_line`, and presents the selected bit downstream with a valid/ready handshake. It sits between the requester bank and the single-bit consumer of the mux output.

## Interface
- `MAX_BURST`, default 4: maximum back-to-back transfers per grant while other requesters wait; legal range 1..15.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  8  request per requester; bit i = requester i.
- `a`  input  8  data bit per requester, mux data inputs.
- `out_ready`  input  1  downstream accepts `y` this cycle.
- `gnt`  output  8  one-hot grant, registered; all-zero when idle.
- `select_line`  output  3  registered mux select, equal to the index of the `gnt` bit.
- `y`  output  1  mux output `a[select_line]`, combinational from current `a`.
- `y_valid`  output  1  registered; `y` is valid for transfer.

## Operation
- States: IDLE (no grant) and GRANT (one requester owns the mux).
- Registers: `last_idx` (3 bit) is the most recently granted index. `burst_cnt` ($clog2(MAX_BURST+1) bits) counts transfers in the current grant.
- Search order for a new grant: `last_idx+1`, `last_idx+2`, and so on, 3-bit wrap-around (7+1 = 0). The first asserted `req` in that order wins.
- IDLE: if `req != 0`, next state is GRANT with the winner's `gnt` bit set, `select_line` = winner, `y_valid` = 1, `last_idx` = winner, `burst_cnt` = 0. Otherwise remain in IDLE.
- Transfer occurs on a cycle with `y_valid && out_ready`.
- GRANT, when a transfer occurs:
  - `burst_cnt` increments.
  - Keep the holder if `req[holder]` is still 1 AND either (`burst_cnt+1 < MAX_BURST`) or no other `req` bit is set. If the holder is kept only because no other `req` bit is set, `burst_cnt` resets to 0.
  - Otherwise re-arbitrate on the same edge. If the search finds a winner, move to GRANT with that winner. If `req == 0`, go to IDLE with `gnt` = 0, `y_valid` = 0.
- GRANT with no transfer: outputs hold.
  - Exception: if `req[holder]` = 0 (abort), re-arbitrate on that edge exactly as above. The aborted item is dropped.
- `gnt` is always one-hot or zero. `select_line` changes only when `gnt` changes.

## Timing
- Reset values: `gnt` = 8'b0, `select_line` = 3'b000, `y_valid` = 0, state = IDLE, `last_idx` = 3'd7 (so the first search starts at 0), `burst_cnt` = 0.
- Latency: `req` asserted in cycle n from IDLE gives `gnt`/`y_valid` in cycle n+1.
- Handoff: from GRANT to a new grant takes 0 bubble cycles. A transfer in cycle n gives the new grant in cycle n+1.
- Backpressure: while `out_ready` = 0, `gnt`, `select_line` and `y_valid` are stable and `burst_cnt` is frozen.
- `y` follows `a` combinationally. The requester must hold `a[i]` stable while granted and not yet transferred.
- Reset asserted mid-grant: all outputs take reset values immediately, without waiting for a clock edge. Any pending item is lost.

## Configuration
- `MUX8_ARB_PRIO_EN` defined: requester 0 is high-priority. At every arbitration point (IDLE with requests, or the end of a grant), if `req[0]` = 1 it wins regardless of `last_idx`. It never preempts a grant mid-burst. `last_idx` still updates to 0.
- Not defined: pure round-robin for all eight requesters.

## Structure
- Shared package `mux8_pkg`: `localparam NUM_REQ = 8`, `SEL_W = 3`, and the state enum `{IDLE, GRANT}`.
- Sub-module: instantiate the existing `mux8` (ports `a`, `select_line`, `y`) for the datapath. The round-robin search is a function inside the arbiter.

## Test plan
- Reset: assert `rst` with `req` = 8'hFF -> `gnt` = 0, `select_line` = 0, `y_valid` = 0. After release, the first grant goes to requester 0.
- Fairness: `MAX_BURST` = 1, `req` = 8'b1010_1010, `a` = 8'b1010_1010, `out_ready` = 1 -> grants 1, 3, 5, 7, 1 on consecutive cycles, with `y` = 1 each cycle.
- Bursting: `MAX_BURST` = 4, `req` = 8'b0000_0011, `out_ready` = 1 -> 4 transfers on `select_line` 0, then 4 on `select_line` 1, repeating.
- Sole requester: `req` = 8'b0000_0100 held for 10 cycles -> `gnt` = 8'b0000_0100 for all 10 cycles, 10 transfers.
- Backpressure/abort: granted to 2, `out_ready` = 0 for 5 cycles -> outputs stable. Then drop `req[2]` with `req[6]` = 1 -> next cycle `gnt` = 8'b0100_0000.
- With `MUX8_ARB_PRIO_EN`: requester 5 holding, `MAX_BURST` = 2, `req[0]` rises -> after 5's second transfer, `gnt` = 8'b0000_0001.
